mul_radix2_host: RTL and testbench

Host-side initiator for the 4-bit nibble-serial multiplier link used by `mul_radix2`. It accepts a pair of BIT_WIDTH operands on a valid/ready port and serializes them onto the link LSB-nibble first, A then B. It collects the returned result nibbles and presents the truncated BIT_WIDTH product on a valid/ready result port with an error flag. It sits between the MAC4 control logic and the multiplier core, so no other block drives the nibble protocol directly.

---
 rtl/mac4_link_pkg.sv | 28 ++
 rtl/nibble_deser.sv | 64 ++++++
 rtl/mul_radix2_host.sv | 184 ++++++++++++++++++
 tb/tb_mul_radix2_host.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac4_link_pkg.sv
// Shared types and helpers for the host side of the nibble-serial multiplier link.
package mac4_link_pkg;

   localparam int unsigned NIBBLE_W   = 4;
   localparam int unsigned LINK_MAX_W = 64;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RDY,
      SEND,
      WAIT_DONE,
      HOLD
   } link_state_t;

   // Nibble idx of a word zero-extended to LINK_MAX_W bits.
   function automatic logic [NIBBLE_W-1:0] get_nibble(input logic [LINK_MAX_W-1:0] word,
                                                      input int unsigned          idx);
      logic [NIBBLE_W-1:0] nib;
      nib = '0;
      for (int unsigned i = 0; i < LINK_MAX_W / NIBBLE_W; i++) begin
         if (i == idx) begin
            nib = word[i*NIBBLE_W +: NIBBLE_W];
         end
      end
      return nib;
   endfunction

endpackage

// File: rtl/nibble_deser.sv
// Result collector: packs incoming nibbles LSB-first, saturating at NIBBLES with an overflow flag.
module nibble_deser
   import mac4_link_pkg::*;
#(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clear,
   input  logic                        enable,
   input  logic                        nib_valid,
   input  logic [NIBBLE_W-1:0]         nib,
   output logic [NIBBLES*NIBBLE_W-1:0] data,
   output logic                        count_ok_c,
   output logic                        overflow_c
);

   localparam int unsigned DATA_W = NIBBLES * NIBBLE_W;
   localparam int unsigned CNT_W  = $clog2(NIBBLES + 1);

   logic [DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;

   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      if (clear) begin
         data_d = '0;
         cnt_d  = '0;
         ovf_d  = 1'b0;
      end else if (enable && nib_valid) begin
         if (cnt_q == CNT_W'(NIBBLES)) begin
            ovf_d = 1'b1;
         end else begin
            for (int unsigned i = 0; i < NIBBLES; i++) begin
               if (cnt_q == CNT_W'(i)) begin
                  data_d[i*NIBBLE_W +: NIBBLE_W] = nib;
               end
            end
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
      end
   end

   // Look-ahead status so a nibble landing with completion is counted.
   assign data       = data_q;
   assign count_ok_c = (cnt_d == CNT_W'(NIBBLES));
   assign overflow_c = ovf_d;

endmodule

// File: rtl/mul_radix2_host.sv
// Host initiator for the nibble-serial multiplier: serializes A then B, collects the product.
module mul_radix2_host
   import mac4_link_pkg::*;
#(
   parameter int unsigned BIT_WIDTH      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 op_valid,
   output logic                 op_ready,
   input  logic [BIT_WIDTH-1:0] op_a,
   input  logic [BIT_WIDTH-1:0] op_b,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [BIT_WIDTH-1:0] res_data,
   output logic                 res_error,
   output logic                 mul_start,
   output logic [3:0]           mul_data_in,
   input  logic                 mul_ready,
   input  logic [3:0]           mul_data_out,
   input  logic                 mul_data_out_valid,
   input  logic                 mul_result_complete
);

   localparam int unsigned NIBBLES = BIT_WIDTH / NIBBLE_W;
   localparam int unsigned SEND_N  = 2 * NIBBLES;
   localparam int unsigned IDX_W   = $clog2(SEND_N);
   localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

   link_state_t          state_q, state_d;
   logic [BIT_WIDTH-1:0] op_a_q, op_a_d;
   logic [BIT_WIDTH-1:0] op_b_q, op_b_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic                 done_q, done_d;
   logic                 mul_start_q, mul_start_d;
   logic [3:0]           mul_data_in_q, mul_data_in_d;
   logic                 res_valid_q, res_valid_d;
   logic                 res_error_q, res_error_d;

   logic                 col_clear;
   logic                 col_enable;
   logic                 col_count_ok;
   logic                 col_overflow;
   logic                 tmo_hit;
   logic                 done_any;
   logic                 collect_err;

   nibble_deser #(
      .NIBBLES (NIBBLES)
   ) u_deser (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (col_clear),
      .enable     (col_enable),
      .nib_valid  (mul_data_out_valid),
      .nib        (mul_data_out),
      .data       (res_data),
      .count_ok_c (col_count_ok),
      .overflow_c (col_overflow)
   );

   assign col_enable  = (state_q == SEND) || (state_q == WAIT_DONE);
   assign tmo_hit     = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
   assign done_any    = done_q || mul_result_complete;
   assign collect_err = !col_count_ok || col_overflow;

   // Next state, operand latch, send index and timeout.
   always_comb begin
      state_d     = state_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      idx_d       = idx_q;
      tmo_d       = tmo_q;
      done_d      = done_q;
      res_error_d = res_error_q;
      col_clear   = 1'b0;

      if (state_q != IDLE && state_q != HOLD) begin
         tmo_d = tmo_q + TMO_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (op_valid) begin
               op_a_d      = op_a;
               op_b_d      = op_b;
               tmo_d       = '0;
               done_d      = 1'b0;
               res_error_d = 1'b0;
               col_clear   = 1'b1;
               state_d     = WAIT_RDY;
            end
         end
         WAIT_RDY: begin
            if (mul_ready) begin
               idx_d   = '0;
               state_d = SEND;
            end else if (tmo_hit) begin
               res_error_d = 1'b1;
               state_d     = HOLD;
            end
         end
         SEND: begin
            done_d = done_any;
            if (idx_q == IDX_W'(SEND_N - 1) && done_any) begin
               res_error_d = collect_err;
               state_d     = HOLD;
            end else if (tmo_hit) begin
               res_error_d = 1'b1;
               state_d     = HOLD;
            end else if (idx_q == IDX_W'(SEND_N - 1)) begin
               state_d = WAIT_DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         WAIT_DONE: begin
            if (mul_result_complete) begin
               res_error_d = collect_err;
               state_d     = HOLD;
            end else if (tmo_hit) begin
               res_error_d = 1'b1;
               state_d     = HOLD;
            end
         end
         HOLD: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Link and result outputs are registered from the upcoming state.
   always_comb begin
      mul_start_d   = 1'b0;
      mul_data_in_d = '0;
      res_valid_d   = (state_d == HOLD);
      if (state_d == SEND) begin
         mul_start_d = (idx_d == '0);
         if (idx_d < IDX_W'(NIBBLES)) begin
            mul_data_in_d = get_nibble(LINK_MAX_W'(op_a_q), 32'(idx_d));
         end else begin
            mul_data_in_d = get_nibble(LINK_MAX_W'(op_b_q), 32'(idx_d - IDX_W'(NIBBLES)));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         op_a_q        <= '0;
         op_b_q        <= '0;
         idx_q         <= '0;
         tmo_q         <= '0;
         done_q        <= 1'b0;
         mul_start_q   <= 1'b0;
         mul_data_in_q <= '0;
         res_valid_q   <= 1'b0;
         res_error_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_a_q        <= op_a_d;
         op_b_q        <= op_b_d;
         idx_q         <= idx_d;
         tmo_q         <= tmo_d;
         done_q        <= done_d;
         mul_start_q   <= mul_start_d;
         mul_data_in_q <= mul_data_in_d;
         res_valid_q   <= res_valid_d;
         res_error_q   <= res_error_d;
      end
   end

   assign op_ready    = (state_q == IDLE);
   assign mul_start   = mul_start_q;
   assign mul_data_in = mul_data_in_q;
   assign res_valid   = res_valid_q;
   assign res_error   = res_error_q;

endmodule

// File: tb/tb_mul_radix2_host.sv
// Directed bench for mul_radix2_host with a behavioural nibble-serial core model.
module tb_mul_radix2_host;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        op_valid;
   logic        op_ready;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic        res_error;
   logic        mul_start;
   logic [3:0]  mul_data_in;
   logic        mul_ready;
   logic [3:0]  mul_data_out;
   logic        mul_data_out_valid;
   logic        mul_result_complete;

   int tests = 0;
   int fails = 0;

   // Core model controls, set by the stimulus before each operation.
   int          base;
   int          n_emit;
   bit          no_complete;
   logic [15:0] model_prod;

   // Core model state.
   bit          active;
   int          phase;
   int          start_cnt;
   int          jm;
   logic [15:0] sh;
   logic [3:0]  sent [0:8];
   logic [31:0] seq;
   int          cyc;

   mul_radix2_host #(
      .BIT_WIDTH      (16),
      .TIMEOUT_CYCLES (1024)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .op_valid            (op_valid),
      .op_ready            (op_ready),
      .op_a                (op_a),
      .op_b                (op_b),
      .res_valid           (res_valid),
      .res_ready           (res_ready),
      .res_data            (res_data),
      .res_error           (res_error),
      .mul_start           (mul_start),
      .mul_data_in         (mul_data_in),
      .mul_ready           (mul_ready),
      .mul_data_out        (mul_data_out),
      .mul_data_out_valid  (mul_data_out_valid),
      .mul_result_complete (mul_result_complete)
   );

   always #5 clk = ~clk;

   // Core model: records sent nibbles by phase, emits result nibbles from 'base'.
   always @(negedge clk) begin
      mul_data_out_valid  = 1'b0;
      mul_data_out        = 4'h0;
      mul_result_complete = 1'b0;
      if (!rst_n) begin
         active = 1'b0;
      end else begin
         if (mul_start) begin
            active = 1'b1;
            phase  = 0;
            start_cnt++;
         end else if (active) begin
            phase++;
         end
         if (active) begin
            if (phase <= 8) sent[phase] = mul_data_in;
            jm = phase - base;
            if (jm >= 0 && jm < n_emit) begin
               mul_data_out_valid = 1'b1;
               sh = (jm < 4) ? (model_prod >> (4 * jm)) : 16'h0;
               mul_data_out = sh[3:0];
            end
            if (!no_complete && phase == base + ((n_emit > 0) ? n_emit - 1 : 0)) begin
               mul_result_complete = 1'b1;
               active = 1'b0;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_sent();
      for (int i = 0; i <= 8; i++) sent[i] = 'x;
      start_cnt = 0;
   endtask

   task automatic accept(input logic [15:0] a, input logic [15:0] b);
      int n;
      n = 0;
      @(negedge clk);
      while (!op_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("op_ready_wait", 32'(op_ready), 32'd1);
      op_valid = 1'b1;
      op_a     = a;
      op_b     = b;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      op_a     = 16'($urandom);
      op_b     = 16'($urandom);
   endtask

   task automatic wait_res(output int c);
      c = 0;
      while (!res_valid && c < 3000) begin
         @(negedge clk);
         c++;
      end
      check("res_valid_wait", 32'(res_valid), 32'd1);
   endtask

   task automatic finish_res(input string tag, input logic [15:0] d, input logic e);
      check({tag, "_data"}, 32'(res_data), 32'(d));
      check({tag, "_err"}, 32'(res_error), 32'(e));
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      check({tag, "_ready_after"}, 32'(op_ready), 32'd1);
      check({tag, "_valid_after"}, 32'(res_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      op_valid    = 1'b0;
      op_a        = '0;
      op_b        = '0;
      res_ready   = 1'b0;
      mul_ready   = 1'b1;
      base        = 8;
      n_emit      = 4;
      no_complete = 1'b0;
      model_prod  = '0;
      active      = 1'b0;
      phase       = 0;
      start_cnt   = 0;
      #12;
      check("rst_op_ready", 32'(op_ready), 32'd1);
      check("rst_mul_start", 32'(mul_start), 32'd0);
      check("rst_mul_data_in", 32'(mul_data_in), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_data", 32'(res_data), 32'd0);
      check("rst_res_error", 32'(res_error), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Zero operands, single start pulse, exact start timing.
      clear_sent();
      model_prod = 16'h0000;
      accept(16'h0000, 16'h0000);
      @(negedge clk);
      check("t1_start_e1", 32'(mul_start), 32'd0);
      check("t1_busy", 32'(op_ready), 32'd0);
      @(negedge clk);
      check("t1_start_e2", 32'(mul_start), 32'd1);
      wait_res(cyc);
      finish_res("t1", 16'h0000, 1'b0);
      check("t1_start_cnt", 32'(start_cnt), 32'd1);
      seq = {sent[7], sent[6], sent[5], sent[4], sent[3], sent[2], sent[1], sent[0]};
      check("t1_seq", seq, 32'h0000_0000);
      check("t1_after_send", 32'(sent[8]), 32'd0);

      // 0x1234 x 0x5678: nibble order 4,3,2,1,8,7,6,5; product truncated to 0x0060.
      clear_sent();
      model_prod = 16'h0060;
      accept(16'h1234, 16'h5678);
      wait_res(cyc);
      finish_res("t2", 16'h0060, 1'b0);
      seq = {sent[7], sent[6], sent[5], sent[4], sent[3], sent[2], sent[1], sent[0]};
      check("t2_seq", seq, 32'h5678_1234);
      check("t2_after_send", 32'(sent[8]), 32'd0);
      check("t2_start_cnt", 32'(start_cnt), 32'd1);

      // 34 x 26 = 884: result arrives during B phase, completion on the last send cycle.
      base       = 4;
      model_prod = 16'h0374;
      accept(16'd34, 16'd26);
      wait_res(cyc);
      finish_res("t3", 16'h0374, 1'b0);

      // Only three result nibbles: short count error, top nibble stays 0.
      base       = 8;
      n_emit     = 3;
      model_prod = 16'hFE01;
      accept(16'h00FF, 16'h00FF);
      wait_res(cyc);
      finish_res("t4", 16'h0E01, 1'b1);

      // Five result nibbles: fifth dropped, overflow error.
      n_emit = 5;
      accept(16'h00FF, 16'h00FF);
      wait_res(cyc);
      finish_res("t5", 16'hFE01, 1'b1);

      // Core never completes: timeout with two partial nibbles kept.
      n_emit      = 2;
      no_complete = 1'b1;
      model_prod  = 16'h00C3;
      accept(16'h0003, 16'h0041);
      wait_res(cyc);
      check("t6_tmo_window", 32'((cyc >= 1020) && (cyc <= 1030)), 32'd1);
      finish_res("t6", 16'h00C3, 1'b1);
      no_complete = 1'b0;

      // Result held under backpressure; new op_valid ignored.
      n_emit     = 4;
      model_prod = 16'h002A;
      accept(16'h0007, 16'h0006);
      wait_res(cyc);
      op_valid = 1'b1;
      op_a     = 16'h1111;
      op_b     = 16'h2222;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t7_hold_data", 32'(res_data), 32'h002A);
         check("t7_hold_err", 32'(res_error), 32'd0);
         check("t7_hold_valid", 32'(res_valid), 32'd1);
         check("t7_hold_busy", 32'(op_ready), 32'd0);
      end
      op_valid = 1'b0;
      finish_res("t7", 16'h002A, 1'b0);

      // Asynchronous reset in the middle of SEND.
      model_prod = 16'h0001;
      accept(16'hFFFF, 16'hFFFF);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("t8_pre_rst_nib", 32'(mul_data_in), 32'hF);
      #2;
      rst_n = 1'b0;
      #1;
      check("t8_rst_start", 32'(mul_start), 32'd0);
      check("t8_rst_nib", 32'(mul_data_in), 32'd0);
      check("t8_rst_valid", 32'(res_valid), 32'd0);
      check("t8_rst_ready", 32'(op_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Operation after reset completes normally.
      model_prod = 16'h000C;
      accept(16'h0003, 16'h0004);
      wait_res(cyc);
      finish_res("t9", 16'h000C, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
